// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants and the majority vote used by the line filter.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_async_if.sv
// Receiver-side bundle: line, frame format, host strobes and received-data/status.
interface uart_rx_async_if;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic       clear_errors;
  logic       fifo_full;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       fifo_write;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  modport master (
    output baud_clock, rx, bit8, parity_en, odd_n_even,
    output read_rx_byte, clear_errors, fifo_full,
    input  rx_byte, rx_ready, fifo_write, parity_err, framing_err, overflow
  );

  modport slave (
    input  baud_clock, rx, bit8, parity_en, odd_n_even,
    input  read_rx_byte, clear_errors, fifo_full,
    output rx_byte, rx_ready, fifo_write, parity_err, framing_err, overflow
  );
endinterface

// File: rtl/uart_rx_filter.sv
// Synchroniser chain on the asynchronous rx line followed by a 3-sample
// majority vote taken on the 16x baud enable.
module uart_rx_filter
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_clock,
  input  logic rx,
  output logic rx_f
);

  logic [SYNC_STAGES-1:0] sync;
  logic [2:0]             taps;

  // Idle-high reset values keep the FSM from seeing a start edge out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      taps <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (baud_clock) taps <= {taps[1:0], sync[SYNC_STAGES-1]};
    end
  end

  assign rx_f = majority3(taps);

endmodule

// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver: 16x oversampled frame FSM with optional parity,
// delivering to a holding register (RX_FIFO=0) or an external FIFO (RX_FIFO=1).
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int RX_FIFO     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_async_if.slave  bus
);

  logic       rx_f;
  rx_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       deliver, par_set, frm_set, last_bit;

  uart_rx_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
    .clk        (clk),
    .reset      (reset),
    .baud_clock (bus.baud_clock),
    .rx         (bus.rx),
    .rx_f       (rx_f)
  );

  assign last_bit = bus.bit8 ? (idx == 3'd7) : (idx == 3'd6);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_HIGH;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    deliver   = 1'b0;
    par_set   = 1'b0;
    frm_set   = 1'b0;
    if (bus.baud_clock) begin
      unique case (state)
        WAIT_HIGH: if (rx_f) state_nxt = IDLE;
        IDLE: begin
          cnt_nxt = '0;
          if (!rx_f) state_nxt = START;
        end
        START: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == MID_SAMPLE) begin
            cnt_nxt = '0;
            if (rx_f) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              idx_nxt   = '0;
              shreg_nxt = '0;
            end
          end
        end
        DATA: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == LAST_SAMPLE) begin
            shreg_nxt[idx] = rx_f;
            if (last_bit) state_nxt = bus.parity_en ? PARITY : STOP;
            else          idx_nxt   = idx + 3'd1;
          end
        end
        PARITY: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == LAST_SAMPLE) begin
            par_set   = (rx_f != (bus.odd_n_even ^ (^shreg)));
            state_nxt = STOP;
          end
        end
        STOP: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == LAST_SAMPLE) begin
            deliver   = 1'b1;
            frm_set   = !rx_f;
            state_nxt = rx_f ? IDLE : WAIT_HIGH;
          end
        end
        default: state_nxt = WAIT_HIGH;
      endcase
    end
  end

  // Host strobes act every clk; an error set in the same clk as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rx_byte     <= '0;
      bus.rx_ready    <= 1'b0;
      bus.fifo_write  <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.fifo_write <= 1'b0;
      if (bus.read_rx_byte) bus.rx_ready <= 1'b0;
      if (bus.clear_errors) begin
        bus.parity_err  <= 1'b0;
        bus.framing_err <= 1'b0;
        bus.overflow    <= 1'b0;
      end
      if (par_set) bus.parity_err  <= 1'b1;
      if (frm_set) bus.framing_err <= 1'b1;
      if (deliver) begin
        if (RX_FIFO == 0) begin
          if (bus.rx_ready && !bus.read_rx_byte) begin
            bus.overflow <= 1'b1;
          end else begin
            bus.rx_byte  <= shreg;
            bus.rx_ready <= 1'b1;
          end
        end else begin
          if (bus.fifo_full) begin
            bus.overflow <= 1'b1;
          end else begin
            bus.rx_byte    <= shreg;
            bus.fifo_write <= 1'b1;
          end
        end
      end
    end
  end

endmodule
